// File: rtl/mispred_arbiter_pkg.sv
// Shared types for the mispredict/redirect arbiter: sequence numbers, the branch
// redirect payload, arbiter state encoding and the default replay timeout.
package mispred_arbiter_pkg;
  localparam int SQN_W           = 7;
  localparam int PC_W            = 32;
  localparam int MISPRED_TIMEOUT = 4;

  typedef logic [SQN_W-1:0] SqN;

  typedef struct packed {
    logic            taken;
    logic            flush;
    SqN              sqN;
    logic [PC_W-1:0] dstPC;
  } BranchProv;

  typedef enum logic [1:0] {
    MA_IDLE   = 2'd0,
    MA_FLUSH  = 2'd1,
    MA_REPLAY = 2'd2
  } MispredArbState_t;

  // a is older than b when the wrapped difference is negative
  function automatic logic sqn_older(SqN a, SqN b);
    SqN d;
    d = a - b;
    return d[SQN_W-1];
  endfunction
endpackage

// File: rtl/mispred_arbiter_if.sv
// Redirect sources, commit-side status and broadcast redirect of the arbiter.
interface mispred_arbiter_if #(parameter int NUM_SRC = 4);
  import mispred_arbiter_pkg::*;

  BranchProv               IN_robBranch;
  BranchProv [NUM_SRC-1:0] IN_branches;
  SqN                      IN_curSqN;
  logic                    IN_mispredFlush;
  BranchProv               OUT_branch;
  logic                    OUT_busy;
  logic [7:0]              OUT_dropCnt;

  modport master (
    output IN_robBranch, IN_branches, IN_curSqN, IN_mispredFlush,
    input  OUT_branch, OUT_busy, OUT_dropCnt
  );

  modport slave (
    input  IN_robBranch, IN_branches, IN_curSqN, IN_mispredFlush,
    output OUT_branch, OUT_busy, OUT_dropCnt
  );
endinterface

// File: rtl/mispred_arbiter_sqn_oldest_sel.sv
// Combinational oldest-select: one-hot of the oldest valid sqN, ties to the lowest index.
module sqn_oldest_sel
  import mispred_arbiter_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         [N-1:0] vld,
  input  SqN           [N-1:0] sqn,
  output logic         [N-1:0] win_oh
);
  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [N-1:0] beats;
    // lane i must be strictly older than lower lanes and no younger than higher lanes
    always_comb begin
      for (int j = 0; j < N; j++) begin
        if (j == i || !vld[j]) beats[j] = 1'b1;
        else if (j < i)        beats[j] = sqn_older(sqn[i], sqn[j]);
        else                   beats[j] = !sqn_older(sqn[j], sqn[i]);
      end
    end
    assign win_oh[i] = vld[i] & (&beats);
  end
endmodule

// File: rtl/mispred_arbiter.sv
// Picks the oldest live redirect among commit and execution sources, broadcasts it
// registered, and blocks younger redirects until the rename replay completes.
module mispred_arbiter
  import mispred_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int TIMEOUT = MISPRED_TIMEOUT
) (
  input logic              clk,
  input logic              rst_n,
  mispred_arbiter_if.slave bus
);
  localparam int NS = NUM_SRC + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE   = MA_IDLE;
  localparam logic [1:0] S_FLUSH  = MA_FLUSH;
  localparam logic [1:0] S_REPLAY = MA_REPLAY;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  SqN            last_sqn_q, last_sqn_d;
  logic [7:0]    drop_q, drop_d;
  BranchProv     out_q, out_d;

  BranchProv [NS-1:0] src;
  SqN        [NS-1:0] src_sqn;
  logic      [NS-1:0] taken, elig, win_oh;
  BranchProv          win;
  logic               issue;
  logic [8:0]         drop_sum;

  always_comb begin
    src[0] = bus.IN_robBranch;
    for (int k = 0; k < NUM_SRC; k++) src[k+1] = bus.IN_branches[k];
  end

  // live = not behind commit; while busy, only redirects older than the last issue count
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      src_sqn[i] = src[i].sqN;
      taken[i]   = src[i].taken;
      elig[i]    = src[i].taken && !sqn_older(src[i].sqN, bus.IN_curSqN) &&
                   (state_q == S_IDLE || sqn_older(src[i].sqN, last_sqn_q));
    end
  end

  sqn_oldest_sel #(.N(NS)) u_sel (
    .vld    (elig),
    .sqn    (src_sqn),
    .win_oh (win_oh)
  );

  always_comb begin
    win = '0;
    for (int i = 0; i < NS; i++) if (win_oh[i]) win = src[i];
  end

  assign issue = |win_oh;

  always_comb begin
    drop_sum = {1'b0, drop_q} + 9'($countones(taken)) - {8'd0, issue};
    drop_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (issue) begin
      state_d = S_FLUSH;
      timer_d = '0;
    end else begin
      case (state_q)
        S_FLUSH: begin
          if (bus.IN_mispredFlush) begin
            state_d = S_REPLAY;
            timer_d = '0;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        S_REPLAY: if (!bus.IN_mispredFlush) state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    out_d       = out_q;
    out_d.taken = 1'b0;
    last_sqn_d  = last_sqn_q;
    if (issue) begin
      out_d       = win;
      out_d.taken = 1'b1;
      last_sqn_d  = win.sqN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      last_sqn_q <= '0;
      drop_q     <= '0;
      out_q      <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      last_sqn_q <= last_sqn_d;
      drop_q     <= drop_d;
      out_q      <= out_d;
    end
  end

  assign bus.OUT_branch  = out_q;
  assign bus.OUT_busy    = (state_q == S_FLUSH) || (state_q == S_REPLAY);
  assign bus.OUT_dropCnt = drop_q;
endmodule

// File: tb/tb_mispred_arbiter.sv
// Scoreboard bench: the driver predicts each redirect pulse from age distances
// relative to commit; a negedge monitor pops and compares what the arbiter emits.
module tb_mispred_arbiter;
  import mispred_arbiter_pkg::*;

  localparam int NUM_SRC = 4;
  localparam int NS      = NUM_SRC + 1;
  localparam int TO      = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mispred_arbiter_if #(.NUM_SRC(NUM_SRC)) bif ();

  mispred_arbiter #(.NUM_SRC(NUM_SRC), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.slave)
  );

  typedef struct {
    int        cyc;
    BranchProv br;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // reference state as of the most recent clock edge (0 idle, 1 flush, 2 replay)
  int m_st, m_age, m_drop;
  SqN m_last;

  BranchProv src[NS];
  SqN        cur;
  logic      mf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic BranchProv mk(input logic fl, input int sq, input logic [31:0] pc);
    BranchProv b;
    b.taken = 1'b1;
    b.flush = fl;
    b.sqN   = SqN'(sq);
    b.dstPC = pc;
    return b;
  endfunction

  task automatic clr();
    for (int i = 0; i < NS; i++) src[i] = '0;
  endtask

  task automatic model_reset();
    m_st = 0; m_age = 0; m_drop = 0; m_last = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of inputs, predict the edge outcome, advance past the edge.
  task automatic step();
    int best, bestd, d, o, ntk, n_st, n_age, n_drop;
    SqN n_last;
    bif.IN_robBranch = src[0];
    for (int k = 0; k < NUM_SRC; k++) bif.IN_branches[k] = src[k+1];
    bif.IN_curSqN       = cur;
    bif.IN_mispredFlush = mf;
    best = -1; bestd = 0; ntk = 0;
    for (int i = 0; i < NS; i++) begin
      if (src[i].taken) begin
        ntk++;
        d = int'(SqN'(src[i].sqN - cur));          // distance ahead of commit
        o = int'(SqN'(m_last - src[i].sqN));       // how far behind the last issue
        if (d < 64 && (m_st == 0 || (o >= 1 && o <= 64)))
          if (best < 0 || d < bestd) begin best = i; bestd = d; end
      end
    end
    n_drop = m_drop + ntk - ((best >= 0) ? 1 : 0);
    if (n_drop > 255) n_drop = 255;
    n_st = m_st; n_age = m_age; n_last = m_last;
    if (best >= 0) begin
      exp_q.push_back('{cyc + 1, src[best]});
      n_st = 1; n_age = 0; n_last = src[best].sqN;
    end else if (m_st == 1) begin
      if (mf) begin n_st = 2; n_age = 0; end
      else if (m_age == TO - 1) begin n_st = 0; n_age = 0; end
      else n_age = m_age + 1;
    end else if (m_st == 2 && !mf) n_st = 0;
    @(posedge clk);
    #1;
    m_st = n_st; m_age = n_age; m_drop = n_drop; m_last = n_last;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clr();
    mf = 1'b0;
    repeat (n) step();
  endtask

  task automatic rand_phase(input int n);
    repeat (n) begin
      if ($urandom_range(0, 2) == 0) cur = cur + SqN'($urandom_range(0, 2));
      for (int i = 0; i < NS; i++) begin
        src[i] = mk(1'($urandom_range(0, 1)),
                    int'(cur) + int'($urandom_range(0, 40)) - 6, $urandom);
        src[i].taken = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 3) == 0) mf = ~mf;
      step();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", bif.OUT_busy, (m_st != 0));
      chk("dropCnt", bif.OUT_dropCnt, m_drop);
      if (bif.OUT_branch.taken) begin
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          checks++; errors++;
          $display("FAIL pulse: unexpected redirect sqN=%0d at cycle %0d", bif.OUT_branch.sqN, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse.sqN", bif.OUT_branch.sqN, mon_e.br.sqN);
          chk("pulse.flush", bif.OUT_branch.flush, mon_e.br.flush);
          chk("pulse.dstPC", bif.OUT_branch.dstPC, mon_e.br.dstPC);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
        checks++; errors++;
        $display("FAIL pulse: missing redirect sqN=%0d at cycle %0d", exp_q[0].br.sqN, cyc);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    clr(); cur = '0; mf = 1'b0;
    bif.IN_robBranch = '0; bif.IN_branches = '0;
    bif.IN_curSqN = '0; bif.IN_mispredFlush = 1'b0;
    model_reset();
    #1;
    chk("rst.taken", bif.OUT_branch.taken, 0);
    chk("rst.sqN", bif.OUT_branch.sqN, 0);
    chk("rst.dstPC", bif.OUT_branch.dstPC, 0);
    chk("rst.busy", bif.OUT_busy, 0);
    chk("rst.dropCnt", bif.OUT_dropCnt, 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // two exec sources, older one wins, other dropped
    clr(); cur = SqN'(5);
    src[2] = mk(0, 20, 32'h0000_2000);
    src[4] = mk(0, 12, 32'h0000_1200);
    step();
    chk("two_src.sqN", bif.OUT_branch.sqN, 12);
    chk("two_src.dropCnt", bif.OUT_dropCnt, 1);

    // wrap-around: 125 is older than 3 relative to commit at 120
    idle(TO + 2);
    cur = SqN'(120);
    src[1] = mk(0, 125, 32'h0000_7D00);
    src[3] = mk(0, 3, 32'h0000_0300);
    step();
    chk("wrap.sqN", bif.OUT_branch.sqN, 125);

    // preemption by an older redirect, younger one dropped
    idle(TO + 2);
    cur = SqN'(5);
    src[1] = mk(0, 40, 32'h0000_4000);
    step();
    clr();
    src[2] = mk(0, 30, 32'h0000_3000);
    src[3] = mk(0, 50, 32'h0000_5000);
    step();
    chk("preempt.sqN", bif.OUT_branch.sqN, 30);
    clr();
    src[1] = mk(0, 50, 32'h0000_5001);
    step();
    chk("preempt.no_pulse", bif.OUT_branch.taken, 0);

    // tie: commit source wins
    idle(TO + 2);
    src[0] = mk(1, 9, 32'hDEAD_0000);
    src[1] = mk(0, 9, 32'h0000_0900);
    step();
    chk("tie.flush", bif.OUT_branch.flush, 1);
    chk("tie.dstPC", bif.OUT_branch.dstPC, 32'hDEAD_0000);

    // replay sequence, then the empty-replay timeout variant
    idle(TO + 2);
    src[1] = mk(0, 20, 32'h0000_2001);
    step();
    clr(); mf = 1'b1;
    repeat (3) step();
    mf = 1'b0;
    step();
    chk("replay.busy_after_fall", bif.OUT_busy, 0);
    src[1] = mk(0, 21, 32'h0000_2101);
    step();
    clr();
    repeat (TO - 1) step();
    chk("timeout.busy_before", bif.OUT_busy, 1);
    step();
    chk("timeout.busy_after", bif.OUT_busy, 0);

    rand_phase(300);

    // saturate the drop counter, enter REPLAY, then reset asynchronously
    idle(TO + 2);
    cur = SqN'(100);
    for (int i = 0; i < NS; i++) src[i] = mk(0, 90, 32'h0000_5A00);
    repeat (52) step();
    chk("sat.dropCnt", bif.OUT_dropCnt, 255);
    clr();
    src[1] = mk(0, 100, 32'h0000_6400);
    step();
    clr(); mf = 1'b1;
    repeat (2) step();
    chk("replay.busy", bif.OUT_busy, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst.busy", bif.OUT_busy, 0);
    chk("async_rst.dropCnt", bif.OUT_dropCnt, 0);
    chk("async_rst.taken", bif.OUT_branch.taken, 0);
    model_reset();
    @(negedge clk); #1 rst_n = 1'b1;
    idle(TO + 2);

    rand_phase(150);
    idle(TO + 2);
    chk("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mispred_arbiter.md
MISPRED_ARBITER -- requirements
Module: mispred_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, 4, number of execution-side branch/mispredict sources.
REQ-002 SHALL have parameter TIMEOUT, 4, cycles FLUSH waits for replay start before returning to IDLE.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port IN_robBranch  in  BranchProv  trap/fence redirect from commit; arbitration index 0.
REQ-006 SHALL have port IN_branches[NUM_SRC]  in  BranchProv  execution-unit redirects; index k arbitrates as k+1.
REQ-007 SHALL have port IN_curSqN  in  SqN  oldest uncommitted sqN.
REQ-008 SHALL have port IN_mispredFlush  in  1  high while the commit-side rename replay runs.
REQ-009 SHALL have port OUT_branch  out  BranchProv  selected redirect, broadcast to the core.
REQ-010 SHALL have port OUT_busy  out  1  high in FLUSH or REPLAY.
REQ-011 SHALL have port OUT_dropCnt  out  8  saturating count of discarded requests.

Function
REQ-012 Candidate: any source with .taken=1 and $signed(sqN - IN_curSqN) >= 0; taken sources failing this SHALL be dropped.
REQ-013 Age: a older than b iff $signed(a.sqN - b.sqN) < 0 on full SqN width, so wrap-around is handled.
REQ-014 Winner: the oldest candidate; equal sqN SHALL resolve to the lowest arbitration index (commit source wins).
REQ-015 Output SHALL be registered with 1-cycle latency: winner in cycle N -> OUT_branch.taken=1 with all winner fields in N+1.
REQ-016 OUT_branch.taken SHALL be a single-cycle pulse per issue; other fields hold their last value.
REQ-017 Register lastSqN SHALL load the winner sqN on every issue.
REQ-018 States: IDLE, FLUSH, REPLAY (2-bit).
REQ-019 IDLE: any candidate -> issue, go to FLUSH, clear timer.
REQ-020 FLUSH: IN_mispredFlush=1 -> REPLAY; timer reaching TIMEOUT-1 with no rise -> IDLE (empty replay).
REQ-021 REPLAY: IN_mispredFlush=0 -> IDLE.
REQ-022 In FLUSH/REPLAY, a candidate strictly older than lastSqN SHALL issue (preempt), re-enter FLUSH, and clear the timer.
REQ-023 In FLUSH/REPLAY, candidates not older than lastSqN SHALL be dropped.
REQ-024 Every taken source that is not issued SHALL add 1 to OUT_dropCnt (multiple per cycle summed), saturating at 255.
REQ-025 Preemption in the same cycle as an IN_mispredFlush transition SHALL take priority: next state FLUSH.
REQ-026 OUT_busy SHALL be combinational from state, high in FLUSH and REPLAY.

Reset
REQ-027 While rst_n=0, asynchronously: state=IDLE, OUT_branch.taken=0, lastSqN=0, timer=0, OUT_dropCnt=0.
REQ-028 OUT_branch payload fields SHALL reset to 0.
REQ-029 Deassertion of rst_n SHALL be usable in any cycle; the first issue is possible on the first edge after deassertion.
REQ-030 Reset mid-FLUSH/REPLAY SHALL abandon the pending redirect with no further output pulse.

Structure
REQ-031 BranchProv and SqN SHALL come from the shared package, along with a new MispredArbState_t enum and MISPRED_TIMEOUT constant.
REQ-032 Oldest-select logic SHALL be a sub-module sqn_oldest_sel: combinational, (NUM_SRC+1) valid/sqN in, one-hot winner out.
REQ-033 Total RTL SHALL stay within 120-400 lines.

Verification
REQ-034 Two sources: exec1 sqN=20 and exec3 sqN=12, IN_curSqN=5 -> next cycle one pulse with sqN=12; OUT_dropCnt=1; state FLUSH.
REQ-035 Wrap-around: IN_curSqN=120, exec0 sqN=125 and exec2 sqN=3 -> sqN=125 issued; sqN=3 dropped.
REQ-036 Preemption: issue sqN=40; next cycle exec1 sqN=30 -> second pulse with sqN=30, FLUSH retained. Same cycle, sqN=50 -> dropped, no pulse.
REQ-037 Tie: ROB sqN=9 and exec0 sqN=9 together -> ROB payload (flush=1, its dstPC) issued; exec dropped.
REQ-038 Replay sequence: issue, then IN_mispredFlush high 3 cycles then low -> FLUSH->REPLAY->IDLE, OUT_busy low the cycle after the fall. Variant with no replay -> IDLE after 4 cycles.
REQ-039 Assert rst_n=0 mid-REPLAY with dropCnt=255 -> immediately IDLE, dropCnt=0, OUT_branch.taken=0 without a clock edge.
